// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial 8-bit subtractor D = A - B, LSB first, one borrow flop.
// Request/done slave: start/ready handshake, result and flags registered at completion.
module eight_bit_serial_subtractor (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic       ready_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] d_o,
   output logic       b8_o,
   output logic       ovf_o,
   output logic       z_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] a_q, a_d, b_q, b_d, r_q, r_d, d_q, d_d;
   logic [2:0] cnt_q, cnt_d;
   logic       br_q, br_d, b8_q, b8_d, ovf_q, ovf_d, z_q, z_d;

   logic       abit, bbit, dbit, br_nxt;
   logic [7:0] res;

   // Current bit slice; on the last RUN edge abit/bbit are the original sign bits.
   assign abit   = a_q[0];
   assign bbit   = b_q[0];
   assign dbit   = abit ^ bbit ^ br_q;
   assign br_nxt = (~abit & bbit) | (~(abit ^ bbit) & br_q);
   assign res    = {dbit, r_q[7:1]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      b8_d    = b8_q;
      ovf_d   = ovf_q;
      z_d     = z_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               r_d     = 8'h00;
               br_d    = 1'b0;
               cnt_d   = 3'd0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d   = {1'b0, a_q[7:1]};
            b_d   = {1'b0, b_q[7:1]};
            r_d   = res;
            br_d  = br_nxt;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               d_d     = res;
               b8_d    = br_nxt;
               ovf_d   = (abit ^ bbit) & (dbit ^ abit);
               z_d     = (res == 8'h00);
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         r_q     <= 8'h00;
         br_q    <= 1'b0;
         cnt_q   <= 3'd0;
         d_q     <= 8'h00;
         b8_q    <= 1'b0;
         ovf_q   <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         b8_q    <= b8_d;
         ovf_q   <= ovf_d;
         z_q     <= z_d;
      end
   end

   assign ready_o = (state_q == S_IDLE);
   assign busy_o  = (state_q == S_RUN);
   assign done_o  = (state_q == S_DONE);
   assign d_o     = d_q;
   assign b8_o    = b8_q;
   assign ovf_o   = ovf_q;
   assign z_o     = z_q;

endmodule

// File: tb/tb_eight_bit_serial_subtractor.sv
// Directed bench for eight_bit_serial_subtractor with hand-computed results.
module tb_eight_bit_serial_subtractor;

   logic       clk, rst_n, start;
   logic [7:0] A, B;
   logic       ready, busy, done, b8, ovf, z;
   logic [7:0] D;

   int tests = 0;
   int fails = 0;
   logic [7:0] prev_d = 8'h00;

   eight_bit_serial_subtractor dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (start),
      .a_i     (A),
      .b_i     (B),
      .ready_o (ready),
      .busy_o  (busy),
      .done_o  (done),
      .d_o     (D),
      .b8_o    (b8),
      .ovf_o   (ovf),
      .z_o     (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 20 && ready !== 1'b1; i++) step();
      chk({tag, " ready"}, ready, 1);
   endtask

   // Runs one operation, checking latency, hold of old D and the final flags.
   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit scramble, input bit extra,
                        input logic [7:0] ed, input logic eb8, input logic eovf, input logic ez);
      int bad;
      wait_ready(tag);
      A = a; B = b; start = 1'b1;
      step();                          // E0
      if (!extra) start = 1'b0;
      if (scramble) begin A = 8'hFF; B = 8'hFF; end
      chk({tag, " busy after accept"}, {ready, busy, done}, 3'b010);
      bad = 0;
      for (int i = 1; i <= 7; i++) begin
         step();                       // E1..E7
         if (busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0 || D !== prev_d) bad++;
      end
      chk({tag, " run phase hold"}, bad, 0);
      step();                          // E8
      start = 1'b0;
      chk({tag, " done state"}, {ready, busy, done}, 3'b001);
      chk({tag, " D"}, D, ed);
      chk({tag, " flags b8/ovf/z"}, {b8, ovf, z}, {eb8, eovf, ez});
      step();                          // E9
      chk({tag, " back to idle"}, {ready, busy, done}, 3'b100);
      prev_d = ed;
   endtask

   initial begin
      int bad, acc1, acc2, acc3, ndone;
      logic pr;
      rst_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00;
      #2;
      chk("reset hs", {ready, busy, done}, 3'b100);
      chk("reset D", D, 8'h00);
      chk("reset flags", {b8, ovf, z}, 3'b000);
      #10 rst_n = 1'b1;
      step();

      do_op("aa-54", 8'hAA, 8'h54, 0, 0, 8'h56, 0, 1, 0);
      do_op("92-89 scr", 8'h92, 8'h89, 1, 0, 8'h09, 0, 0, 0);
      do_op("00-01", 8'h00, 8'h01, 0, 0, 8'hFF, 1, 0, 0);
      do_op("80-01", 8'h80, 8'h01, 0, 0, 8'h7F, 0, 1, 0);
      do_op("3c-3c", 8'h3C, 8'h3C, 0, 0, 8'h00, 0, 0, 1);
      do_op("10-01 extra", 8'h10, 8'h01, 0, 1, 8'h0F, 0, 0, 0);
      step();
      chk("no reaccept after extra", {ready, busy, done}, 3'b100);

      // Abort mid-operation with reset after the 4th RUN edge.
      A = 8'h77; B = 8'h11; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("pre-abort busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort hs", {ready, busy, done}, 3'b100);
      chk("abort D", D, 8'h00);
      chk("abort flags", {b8, ovf, z}, 3'b000);
      #2 rst_n = 1'b1;
      prev_d = 8'h00;
      step();
      do_op("05-03", 8'h05, 8'h03, 0, 0, 8'h02, 0, 0, 0);

      // start held high: acceptances 10 edges apart, one-hot handshake every cycle.
      A = 8'h20; B = 8'h10; start = 1'b1;
      bad = 0; acc1 = -1; acc2 = -1; acc3 = -1; ndone = 0;
      pr = ready;
      for (int n = 1; n <= 22; n++) begin
         step();
         if ((ready + busy + done) != 1) bad++;
         if (done === 1'b1) ndone++;
         if (pr === 1'b1 && busy === 1'b1) begin
            if (acc1 < 0) acc1 = n;
            else if (acc2 < 0) acc2 = n;
            else if (acc3 < 0) acc3 = n;
         end
         pr = ready;
      end
      start = 1'b0;
      chk("held one-hot", bad, 0);
      chk("held first accept", acc1, 1);
      chk("held accept spacing", acc2 - acc1, 10);
      chk("held accept spacing 2", acc3 - acc2, 10);
      chk("held done count", ndone, 2);
      chk("held D", D, 8'h10);
      wait_ready("drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/eight_bit_serial_subtractor.md
# eight_bit_serial_subtractor

Sequential 8-bit subtractor computing D = A − B one bit per clock, LSB first, using a single borrow flip-flop. It is the inverse-operation counterpart to the team's 8-bit ripple-carry adder and trades area for latency. It sits on the datapath as a request/done slave, with a start/ready handshake and registered result plus flags.

## Interface
Parameters: none. Width is fixed at 8.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when ready=1
- A  in  8  minuend, sampled at the accepting edge
- B  in  8  subtrahend, sampled at the accepting edge
- ready  out  1  high only in IDLE
- busy  out  1  high only in RUN
- done  out  1  one-cycle pulse when the result becomes valid
- D  out  8  registered difference A − B mod 256
- b8  out  1  final borrow out; 1 iff A < B unsigned
- ovf  out  1  signed (two's-complement) overflow
- z  out  1  1 iff D == 0

## Operation
- One clock domain. Reset is asynchronous and active-low.
- FSM states:
  - IDLE: ready=1. On an edge with start=1: latch A and B into internal shift registers, clear the borrow flip-flop, clear the 3-bit bit counter, go to RUN.
  - RUN: busy=1. Each edge processes bit i = counter:
    - d = a ^ b ^ br
    - br' = (~a & b) | (~(a ^ b) & br)
    - d shifts into the MSB of an internal result shift register. Operand registers shift right. Counter increments.
    - On the 8th RUN edge: load D from the completed result, set b8 = final br', ovf = (A7 ≠ B7) & (D7 ≠ A7), z = (D == 0). Go to DONE.
  - DONE: done=1 for exactly one cycle, ready=0. Next edge goes to IDLE unconditionally.
- D, b8, ovf and z are updated only at the RUN→DONE edge. They hold stable until the next completion or reset. Intermediate bits never appear on D.
- start is ignored in RUN and DONE. Changes on A and B after acceptance have no effect.
- ready, busy and done decode directly from the state register. Exactly one of the three is high at any time.

## Timing
- Reset values (asynchronous, immediate): state IDLE, ready=1, busy=0, done=0, D=0x00, b8=0, ovf=0, z=0. Internal counter, borrow and shift registers are all 0.
- Latency:
  - Accepting edge E0. RUN spans edges E1..E8. Results are visible after E8, with done=1 in cycle E8→E9.
  - IDLE is re-entered at E9. Earliest next acceptance is E10.
- Throughput: one operation per 10 cycles with start held high.
- Reset asserted in any state aborts the operation. All outputs return to their reset values. The first post-reset operation behaves normally.
- Counter wrap: the counter reaching 7 with a valid bit processed is the terminal condition. The counter is never observed past 7.

## Test plan
- A=0xAA, B=0x54, start pulsed → after 8 RUN cycles done pulses once: D=0x56, b8=0, ovf=1, z=0.
- A=0x92, B=0x89 → D=0x09, b8=0, ovf=0, z=0. Also check that A and B changed to 0xFF during RUN do not alter the result.
- A=0x00, B=0x01 → D=0xFF, b8=1, ovf=0, z=0. Then A=0x80, B=0x01 → D=0x7F, b8=0, ovf=1.
- A=0x3C, B=0x3C → D=0x00, z=1, b8=0, ovf=0. Check that the previous D holds until the completion edge.
- Extra start pulses during RUN and DONE → ignored, no extra done. Then rst_n low after the 4th RUN edge → ready=1, busy=0, D=0x00 immediately. A following 0x05 − 0x03 yields D=0x02.
- start held high across two operations → acceptances exactly 10 cycles apart, done high for one cycle each, and ready/busy/done one-hot at every cycle.
